// File: rtl/signed_add_arbiter.sv
// Round-robin arbiter that shares one signed adder among NUM_REQ requesters.
// Each sum lands in a single-entry result register tagged with the winning requester ID.

module add_nbit_signed #(
    parameter int N = 9
) (
    input  logic signed [N:0]   a,
    input  logic signed [N:0]   b,
    output logic signed [N+1:0] sum
);
    // One guard bit means the sum can never overflow.
    assign sum = {a[N], a} + {b[N], b};
endmodule

module signed_add_arbiter #(
    parameter int DATA_WIDTH = 9,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_a,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_b,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [DATA_WIDTH+1:0]           res_sum,
    output logic [ID_W-1:0]                 res_id,
    output logic [15:0]                     ops_done
);
    localparam int OW = DATA_WIDTH + 1;
    localparam int SW = DATA_WIDTH + 2;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic [ID_W-1:0]      ptr_reg, ptr_next;
    logic [ID_W-1:0]      id_reg, id_next;
    logic [SW-1:0]        sum_reg, sum_next;
    logic [15:0]          ops_reg, ops_next;
    logic [ID_W-1:0]      win;
    logic                 found;
    logic                 can_issue;
    logic                 issue;
    logic signed [OW-1:0] a_arr [NUM_REQ];
    logic signed [OW-1:0] b_arr [NUM_REQ];
    logic signed [OW-1:0] add_a, add_b;
    logic signed [SW-1:0] add_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*OW +: OW];
            assign b_arr[gi]     = req_b[gi*OW +: OW];
            assign req_ready[gi] = issue && (win == ID_W'(gi));
        end
    endgenerate

    // Scan from ptr upwards, wrapping; first valid requester wins.
    always_comb begin
        int idx;
        logic [ID_W-1:0] idx_w;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(ptr_reg) + k) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!found && req_valid[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    assign can_issue = (state_reg == EMPTY) || res_ready;
    assign issue     = found && can_issue && !rst;
    assign add_a     = a_arr[win];
    assign add_b     = b_arr[win];

    add_nbit_signed #(.N(DATA_WIDTH)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        id_next    = id_reg;
        sum_next   = sum_reg;
        ops_next   = ops_reg;
        if (state_reg == FULL && res_ready) begin
            ops_next   = ops_reg + 16'd1;
            state_next = EMPTY;
        end
        if (issue) begin
            state_next = FULL;
            sum_next   = add_sum;
            id_next    = win;
            ptr_next   = ID_W'((int'(win) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            ptr_reg   <= '0;
            id_reg    <= '0;
            sum_reg   <= '0;
            ops_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            id_reg    <= id_next;
            sum_reg   <= sum_next;
            ops_reg   <= ops_next;
        end
    end

    assign res_valid = (state_reg == FULL);
    assign res_sum   = sum_reg;
    assign res_id    = id_reg;
    assign ops_done  = ops_reg;
endmodule
